// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - LEGv8 instruction fetch stage with prefetch FIFO
// Issues word reads from the PC, queues returned words and hands them to decode over valid/ready.

module instruction_fetch_unit #(
    parameter int unsigned         PC_WIDTH    = 64,
    parameter int unsigned         IMEM_BYTES  = 4096,
    parameter int unsigned         FIFO_DEPTH  = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter logic [10:0]         HALT_OPCODE = 11'h7FF
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [31:0]         imem_rdata,
    input  logic                imem_rvalid,
    output logic                if_valid,
    output logic [31:0]         if_instr,
    output logic [PC_WIDTH-1:0] if_pc,
    input  logic                id_ready,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_target,
    output logic                halted,
    output logic                fault
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [PC_WIDTH:0] IMEM_LIMIT = (PC_WIDTH+1)'(IMEM_BYTES);
    localparam logic [PC_WIDTH:0] WORD_BYTES = (PC_WIDTH+1)'(4);
    localparam logic [CNT_W:0]    DEPTH_W    = (CNT_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_HALTED = 2'd1,
        S_FAULT  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] issued_addr_q, issued_addr_d;
    logic                inflight_q, inflight_d;
    logic                kill_q, kill_d;
    logic                stop_fetch_q, stop_fetch_d;
    logic                pending_fault_q, pending_fault_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic [31:0]         fifo_instr_q [FIFO_DEPTH];
    logic [PC_WIDTH-1:0] fifo_pc_q    [FIFO_DEPTH];

    logic                in_run;
    logic                redirect;
    logic                rsp_accept;
    logic                rsp_is_halt;
    logic                fifo_push;
    logic                fifo_pop;
    logic                head_valid;
    logic                head_is_halt;
    logic                xfer_halt;
    logic [31:0]         head_instr;
    logic [PC_WIDTH-1:0] head_pc;
    logic [PC_WIDTH:0]   pc_end;
    logic [PC_WIDTH:0]   target_end;
    logic                pc_in_range;
    logic                target_bad;
    logic [CNT_W:0]      occupancy;
    logic                fetch_ok;
    logic                issue;
    logic                range_fault;

    assign in_run      = (state_q == S_RUN);
    assign redirect    = redirect_valid & in_run;
    assign rsp_accept  = imem_rvalid & ~kill_q & in_run;
    assign rsp_is_halt = (imem_rdata[31:21] == HALT_OPCODE);

    assign head_instr   = fifo_instr_q[rd_ptr_q];
    assign head_pc      = fifo_pc_q[rd_ptr_q];
    assign head_valid   = in_run & (count_q != '0);
    assign head_is_halt = (head_instr[31:21] == HALT_OPCODE);
    assign fifo_pop     = head_valid & id_ready;
    assign xfer_halt    = fifo_pop & head_is_halt;
    // A flush in the same cycle discards the arriving word.
    assign fifo_push    = rsp_accept & ~redirect;

    // Range checks carry one extra bit so an address wrap reads as out of range.
    assign pc_end      = {1'b0, pc_q} + WORD_BYTES;
    assign target_end  = {1'b0, redirect_target} + WORD_BYTES;
    assign pc_in_range = (pc_end <= IMEM_LIMIT);
    assign target_bad  = (redirect_target[1:0] != 2'b00) | (target_end > IMEM_LIMIT);

    // Reserving a slot per outstanding read guarantees a response always fits.
    assign occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};

    // A HALT arriving this cycle already blocks the next request.
    assign fetch_ok = in_run & ~reset & ~stop_fetch_q & ~(rsp_accept & rsp_is_halt)
                    & ~pending_fault_q & ~redirect_valid & (occupancy < DEPTH_W);
    assign issue       = fetch_ok & pc_in_range;
    assign range_fault = fetch_ok & ~pc_in_range;

    assign imem_req  = issue;
    assign imem_addr = issue ? pc_q : '0;
    assign if_valid  = head_valid;
    assign if_instr  = head_valid ? head_instr : '0;
    assign if_pc     = head_valid ? head_pc : '0;
    assign halted    = (state_q == S_HALTED);
    assign fault     = (state_q == S_FAULT);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN: begin
                if (xfer_halt) begin
                    state_d = S_HALTED;
                end else if (pending_fault_q && (count_q == '0) && !inflight_q && !redirect) begin
                    state_d = S_FAULT;
                end
            end
            S_HALTED: state_d = S_HALTED;
            S_FAULT:  state_d = S_FAULT;
            default:  state_d = S_FAULT;
        endcase
    end

    always_comb begin
        pc_d            = pc_q;
        issued_addr_d   = issued_addr_q;
        inflight_d      = inflight_q;
        kill_d          = kill_q;
        stop_fetch_d    = stop_fetch_q;
        pending_fault_d = pending_fault_q;
        rd_ptr_d        = rd_ptr_q;
        wr_ptr_d        = wr_ptr_q;
        count_d         = count_q;

        if (imem_rvalid) begin
            inflight_d = 1'b0;
            kill_d     = 1'b0;
        end
        if (issue) begin
            inflight_d    = 1'b1;
            issued_addr_d = pc_q;
            pc_d          = pc_q + PC_WIDTH'(4);
        end
        if (range_fault) begin
            pending_fault_d = 1'b1;
        end
        if (fifo_push && rsp_is_halt) begin
            stop_fetch_d = 1'b1;
        end

        if (redirect) begin
            rd_ptr_d        = '0;
            wr_ptr_d        = '0;
            count_d         = '0;
            kill_d          = inflight_q & ~imem_rvalid;
            pc_d            = redirect_target;
            stop_fetch_d    = 1'b0;
            pending_fault_d = target_bad;
        end else begin
            if (fifo_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (fifo_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_RUN;
            pc_q            <= RESET_PC;
            issued_addr_q   <= '0;
            inflight_q      <= 1'b0;
            kill_q          <= 1'b0;
            stop_fetch_q    <= 1'b0;
            pending_fault_q <= 1'b0;
            rd_ptr_q        <= '0;
            wr_ptr_q        <= '0;
            count_q         <= '0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            issued_addr_q   <= issued_addr_d;
            inflight_q      <= inflight_d;
            kill_q          <= kill_d;
            stop_fetch_q    <= stop_fetch_d;
            pending_fault_q <= pending_fault_d;
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            count_q         <= count_d;
        end
    end

    // Storage needs no reset: the head is only visible while count is non-zero.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_instr_q[wr_ptr_q] <= imem_rdata;
            fifo_pc_q[wr_ptr_q]    <= issued_addr_q;
        end
    end

endmodule
